muxn_rr_reg: RTL and testbench
==============================

// Module: muxn_rr_reg
// PURPOSE
//  Parametrised N:1 registered multiplexer; successor to the 4-bit 2:1 mux.
//  Selects one of N valid/ready input channels by explicit select or by round-robin.
//  Drives one registered valid/ready output stage.
//  Sits between N producers and one consumer in the datapath.
// PARAMETERS
//  WIDTH  4  data bits per channel (>=1)
//  N      4  number of input channels (>=2); localparam SELW = $clog2(N)
// PORTS
//  clk        in   1        rising-edge clock, single clock domain
//  rst_n      in   1        asynchronous active-low reset
//  in_data    in   N*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
//  in_valid   in   N        per-channel valid
//  in_ready   out  N        per-channel ready (combinational)
//  sel        in   SELW     channel index, used when mode=0
//  mode       in   1        0 = manual select, 1 = round-robin
//  out_data   out  WIDTH    registered selected data
//  out_ch     out  SELW     registered index of the channel held in out_data
//  out_valid  out  1        output holds a word
//  out_ready  in   1        consumer accepts the word
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the system): out_valid=0, out_data=0, out_ch=0, rr_ptr=N-1.
//  - Load enable: ld = !out_valid || out_ready. Output transfer = out_valid && out_ready.
//  - Grant, mode=0: g=sel if sel<N && in_valid[sel]; otherwise no grant.
//    sel>=N never grants, even when channels are valid.
//  - Grant, mode=1: first c with in_valid[c], scanning rr_ptr+1, rr_ptr+2, ... mod N.
//    No grant if none is valid.
//  - in_ready[c] = ld && grant && g==c; at most one bit is set per cycle.
//  - Input transfer on in_valid[g] && in_ready[g].
//    Next edge: out_data<=in_data[g]; out_ch<=g; out_valid<=1.
//  - Transfer with ld=1 and no grant: out_valid<=0. out_data and out_ch hold their values.
//  - ld=0 (stall): out_data, out_ch and out_valid hold; all in_ready=0.
//  - Latency: 1 cycle from input transfer to out_valid.
//  - Full throughput: a new word is accepted in the same cycle as the output transfer.
//  - rr_ptr <= g only on an input transfer in mode=1; mode=0 leaves rr_ptr unchanged.
//  - Wrap-around: with rr_ptr=N-1 the scan starts at channel 0.
//    A single valid channel is granted every cycle.
//  - Changes to mode or sel apply to the next grant only.
//    A word already in the output register is never altered.
//  - Reset mid-transfer: the held word is discarded; out_valid=0 immediately (async).
//  - Unsigned data; out_data is exactly WIDTH bits; no arithmetic on data.
// CONFIGURATION
//  MUXN_PARITY_EN defined:
//    - adds port out_par (out, 1) = even parity ^out_data, registered with out_data.
//    - out_par resets to 0 and follows the same load and hold rules.
//  MUXN_PARITY_EN undefined: no out_par port, no parity logic.
// TESTING (WIDTH=4, N=4 unless noted)
//  1 Manual mode, mode=0, out_ready=1, in_data={F,E,A,5} (ch3..ch0), all valid:
//    sel=0 -> out_data=5, out_ch=0 one cycle later.
//    sel=1 -> out_data=A, out_ch=1.
//  2 Round-robin, mode=1, all valid, out_ready=1, from reset:
//    out_ch sequence 0,1,2,3,0.
//    Only ch1 and ch3 valid -> sequence 1,3,1,3.
//  3 Stall: out_ready=0 with a word held (out_data=A):
//    in_ready=0, and out_data/out_ch/out_valid stable for 5 cycles.
//    out_ready=1 -> the next word loads on the same edge as the transfer.
//  4 Boundaries:
//    N=3, sel=3, all valid -> no grant, out_valid falls to 0 after the pending transfer.
//    No channels valid -> out_valid=0.
//  5 Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0 immediately.
//    After release in mode=1 the first grant goes to ch0.
//  6 Build with MUXN_PARITY_EN, out_data=7 -> out_par=1; out_data=5 -> out_par=0.
//    Build without it: the bench compiles with no out_par port.

Source files
------------

// File: rtl/muxn_rr_reg.sv
// N:1 registered valid/ready multiplexer with manual or round-robin channel selection.
// Define MUXN_PARITY_EN to add a registered even-parity output (out_par).
module muxn_rr_reg #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
`ifdef MUXN_PARITY_EN
  output logic               out_par,
`endif
  input  logic               out_ready
);

  logic [SELW-1:0]  rr_ptr_q;
  logic             ld;
  logic             grant;
  logic [SELW-1:0]  g;
  logic [WIDTH-1:0] g_data;
  int unsigned      sel_u;
  int unsigned      ptr_u;

  assign ld    = !out_valid || out_ready;
  assign sel_u = 32'(sel);
  assign ptr_u = 32'(rr_ptr_q);

  // Round-robin scans offsets N down to 1 so the closest valid channel after
  // rr_ptr is the last one written, i.e. the winner.
  always_comb begin
    grant = 1'b0;
    g     = '0;
    if (!mode) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (sel_u == c && in_valid[c]) begin
          grant = 1'b1;
          g     = SELW'(c);
        end
      end
    end else begin
      for (int unsigned k = N; k >= 1; k--) begin
        for (int unsigned c = 0; c < N; c++) begin
          if (c == (ptr_u + k) % N && in_valid[c]) begin
            grant = 1'b1;
            g     = SELW'(c);
          end
        end
      end
    end
  end

  always_comb begin
    g_data   = '0;
    in_ready = '0;
    for (int unsigned c = 0; c < N; c++) begin
      if (g == SELW'(c)) begin
        g_data = in_data[c*WIDTH +: WIDTH];
      end
      in_ready[c] = ld && grant && (g == SELW'(c));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr_q  <= SELW'(N - 1);
    end else if (ld) begin
      if (grant) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_ch    <= g;
        if (mode) begin
          rr_ptr_q <= g;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUXN_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par <= 1'b0;
    end else if (ld && grant) begin
      out_par <= ^g_data;
    end
  end
`endif

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Directed table-driven bench for muxn_rr_reg (N=4 main instance, N=3 boundary instance).
// Builds with or without MUXN_PARITY_EN.
module tb_muxn_rr_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [3:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
`ifdef MUXN_PARITY_EN
  logic        out_par;
  logic        out_par3;
`endif

  logic [11:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic [3:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muxn_rr_reg #(.WIDTH(4), .N(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
`ifdef MUXN_PARITY_EN
    .out_par   (out_par),
`endif
    .out_ready (out_ready)
  );

  muxn_rr_reg #(.WIDTH(4), .N(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .mode      (1'b0),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_valid (out_valid3),
`ifdef MUXN_PARITY_EN
    .out_par   (out_par3),
`endif
    .out_ready (1'b1)
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_v;
    logic [3:0] exp_d;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r,
                     input logic [3:0] er, input logic ev, input logic [3:0] ed,
                     input logic [1:0] ec);
    vec_t t;
    t.mode = m; t.sel = s; t.valid = v; t.ordy = r;
    t.exp_rdy = er; t.exp_v = ev; t.exp_d = ed; t.exp_ch = ec;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 16'hFEA5;
    in_valid  = '0;
    sel       = '0;
    mode      = 1'b0;
    out_ready = 1'b1;
    in_data3  = 12'hEA5;
    in_valid3 = '0;
    sel3      = '0;

    // mode sel valid ordy | in_ready  valid data ch
    add(0, 0, 4'hF, 1, 4'b0001, 1, 4'h5, 0);  // manual sel0
    add(0, 1, 4'hF, 1, 4'b0010, 1, 4'hA, 1);  // manual sel1
    add(1, 0, 4'hF, 1, 4'b0001, 1, 4'h5, 0);  // rr wraps from ptr=3
    add(1, 0, 4'hF, 1, 4'b0010, 1, 4'hA, 1);
    add(1, 0, 4'hF, 1, 4'b0100, 1, 4'hE, 2);
    add(1, 0, 4'hF, 1, 4'b1000, 1, 4'hF, 3);
    add(1, 0, 4'hF, 1, 4'b0001, 1, 4'h5, 0);
    add(1, 0, 4'hA, 1, 4'b0010, 1, 4'hA, 1);  // only ch1, ch3 valid
    add(1, 0, 4'hA, 1, 4'b1000, 1, 4'hF, 3);
    add(1, 0, 4'hA, 1, 4'b0010, 1, 4'hA, 1);
    add(1, 0, 4'hA, 1, 4'b1000, 1, 4'hF, 3);
    add(1, 0, 4'h0, 1, 4'b0000, 0, 4'hF, 3);  // nothing valid
    add(0, 1, 4'hF, 0, 4'b0010, 1, 4'hA, 1);  // empty output loads despite out_ready=0
    for (int i = 0; i < 5; i++) add(0, 2, 4'hF, 0, 4'b0000, 1, 4'hA, 1);  // stall
    add(0, 2, 4'hF, 1, 4'b0100, 1, 4'hE, 2);  // transfer and load same edge
    add(0, 0, 4'hE, 1, 4'b0000, 0, 4'hE, 2);  // selected channel not valid

    #1;
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_data", 32'(out_data), 0);
    chk("reset_ch", 32'(out_ch), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      mode      = vecs[i].mode;
      sel       = vecs[i].sel;
      in_valid  = vecs[i].valid;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_v));
      chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_d));
      chk($sformatf("v%0d_out_ch", i), 32'(out_ch), 32'(vecs[i].exp_ch));
`ifdef MUXN_PARITY_EN
      chk($sformatf("v%0d_out_par", i), 32'(out_par), 32'(^vecs[i].exp_d));
`endif
    end

`ifdef MUXN_PARITY_EN
    in_data = 16'hFEA7; mode = 0; sel = 0; in_valid = 4'hF; out_ready = 1;
    tick();
    chk("par_7", 32'(out_par), 1);
    in_data = 16'hFEA5;
    tick();
    chk("par_5", 32'(out_par), 0);
`endif

    // Reset mid-stream after moving rr_ptr to 1
    mode = 1; in_valid = 4'hF; out_ready = 1;
    tick();
    tick();
    chk("pre_rst_ch", 32'(out_ch), 1);
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_data", 32'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ch", 32'(out_ch), 0);
    chk("post_rst_valid", 32'(out_valid), 1);

    // N=3 boundary: sel=3 never grants
    in_valid3 = 3'b111; sel3 = 2'd0;
    tick();
    chk("n3_sel0_valid", 32'(out_valid3), 1);
    chk("n3_sel0_data", 32'(out_data3), 5);
    sel3 = 2'd3;
    #1;
    chk("n3_sel3_ready", 32'(in_ready3), 0);
    tick();
    chk("n3_sel3_valid", 32'(out_valid3), 0);
    chk("n3_sel3_data_hold", 32'(out_data3), 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
